led_scan_controller: RTL
========================

# led_scan_controller

Time-multiplexed scan controller for a 4-digit common-anode 7-segment display. It owns a double-buffered 4-nibble display memory and steps through the digits with a blanking gap between them to suppress ghosting. Each step presents the selected nibble on `char` and drives the active-low anode lines. It sits between the register/host logic and the team's hex-to-segment decoder; the top level connects `char` to the decoder input and the decoder output to the cathodes.

## Interface
Parameters:
- `DIGIT_CYCLES`, 50000: cycles each digit's anode is driven; legal range 1..65535.
- `BLANK_CYCLES`, 500: cycles all anodes are off before each digit; legal range 1..65535.

Ports:
- `clk`  in  1  single system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  write strobe into the shadow buffer.
- `wr_addr`  in  2  shadow digit index; 0 is the rightmost digit.
- `wr_data`  in  4  nibble written.
- `commit`  in  1  one-cycle request to copy shadow to active at the next frame boundary.
- `commit_pending`  out  1  high from the cycle after an accepted `commit` until the copy happens.
- `char`  out  4  nibble of the current digit, to the decoder.
- `an`  out  4  anode enables, active-low.
- `frame_done`  out  1  one-cycle pulse at each frame boundary.

## Operation
- State machine: BLANK and DRIVE.
- Digit index `idx` is 0..3. A 16-bit cycle counter `cnt` is used.
- BLANK:
  - `an` = 4'b1111.
  - When `cnt == BLANK_CYCLES-1`: go to DRIVE and set `cnt` to 0. Otherwise increment `cnt`.
- DRIVE:
  - `an` = ~(4'b0001 << idx).
  - When `cnt == DIGIT_CYCLES-1`: go to BLANK, set `cnt` to 0, and set `idx` to idx+1 mod 4.
- `char` = active[idx] in both states. It is stable for the whole BLANK+DRIVE window of a digit.
- Frame boundary: the DRIVE(idx=3) → BLANK(idx=0) transition. In that same edge:
  - If `commit_pending` is set, or `commit` is high in that cycle: active ← shadow and `commit_pending` ← 0.
  - `frame_done` ← 1 for exactly one cycle.
- Shadow writes:
  - Accepted in any cycle, unconditionally.
  - A write in the same cycle as a frame-boundary copy is included in the copied value.
- `commit` while already pending has no additional effect.
- Reset values:
  - state = BLANK, `idx` = 0, `cnt` = 0.
  - shadow and active all 4'h0.
  - `commit_pending` = 0, `frame_done` = 0.
  - `an` = 4'b1111, `char` = 4'h0.
- Reset during any state, including mid-DRIVE or with a commit pending, aborts immediately. All state returns to reset values and the pending commit is discarded.

## Timing
- All outputs are driven from registers, or decoded only from registers. There is no combinational path from any input to any output.
- Frame length = 4 × (BLANK_CYCLES + DIGIT_CYCLES) cycles.
- The first reset-release frame does not pulse `frame_done` at its start.
- `commit_pending` rises one cycle after `commit`. The exception is a `commit` on the frame-boundary cycle: the copy happens on that edge and `commit_pending` stays 0.
- A shadow write appears on `char` only after a commit and the following frame boundary. Worst-case latency is one frame plus 1 cycle.
- Anodes are never low in two digits in the same cycle. At least BLANK_CYCLES all-off cycles separate successive drives.
- `cnt` is 16 bits. Parameters outside the legal range are unsupported.

## Structure
- Package `led_scan_pkg`:
  - state typedef {BLANK, DRIVE}.
  - `NUM_DIGITS` = 4.
  - `CNT_W` = 16.
  - reset constant `AN_OFF` = 4'b1111.
- Sub-module `led_scan_timer`: the `cnt` counter with a terminal-count compare for a selectable limit. Its inputs are the limit, a clear and an enable; it reports terminal count. The FSM, buffers and anode decode stay in `led_scan_controller`.

## Test plan
All scenarios use DIGIT_CYCLES=4 and BLANK_CYCLES=2, giving a 24-cycle frame.

- **Reset:** hold `reset` 3 cycles, then release → `an`=1111 for 2 cycles, then 1110 for 4 cycles, then 1111 for 2 cycles, then 1101. `char`=0 throughout; `frame_done` first pulses at cycle 24 after release.
- **Write and commit:** write 1,2,3,4 to addr 0..3, then pulse `commit` → `commit_pending` goes high the next cycle. At the next boundary `frame_done`=1, `commit_pending`=0, and `char` reads 1, 2, 3, 4 across the following frame with matching `an` 1110, 1101, 1011, 0111.
- **Write without commit:** write 4'hF to addr 2 with no commit → active digits are unchanged for at least 3 frames.
- **Commit on the boundary cycle:** pulse `commit` in the boundary cycle together with a write of 4'hA to addr 0 → digit 0 shows A in the new frame; `commit_pending` never rises.
- **Reset mid-operation:** assert `reset` mid-DRIVE of digit 2 with a commit pending → next cycle `an`=1111, `commit_pending`=0, and all digits show 0.
- **Anode safety checker (runs in all tests):**
  - `an` never has more than one zero bit.
  - Every 1-to-0 anode transition is preceded by at least 2 cycles of 1111.

Source files
------------

// File: rtl/led_scan_pkg.sv
// Shared types and constants for the 4-digit LED scan controller.
package led_scan_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    localparam int          NUM_DIGITS = 4;
    localparam int          CNT_W      = 16;
    localparam logic [3:0]  AN_OFF     = 4'b1111;

    // Active-low one-cold anode mask for the selected digit.
    function automatic logic [3:0] anode_sel(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Phase timer: up-counter with terminal-count compare against a selectable limit.
module led_scan_timer
    import led_scan_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] limit_i,
    input  logic             clear_i,
    input  logic             en_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == limit_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_scan_controller.sv
// Scans a double-buffered 4-nibble display memory across four common-anode
// digits, inserting an all-off gap before each digit to suppress ghosting.
module led_scan_controller
    import led_scan_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       commit,
    output logic       commit_pending,
    output logic [3:0] char,
    output logic [3:0] an,
    output logic       frame_done
);

    localparam logic [CNT_W-1:0] DIGIT_LIM = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES - 1);

    scan_state_e                 state_q, state_d;
    logic [1:0]                  idx_q, idx_d;
    logic [NUM_DIGITS-1:0][3:0]  shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0][3:0]  active_q, active_d;
    logic                        pending_q, pending_d;
    logic                        frame_done_q, frame_done_d;

    logic [CNT_W-1:0]            limit;
    logic                        tc;
    logic                        boundary;

    assign limit = (state_q == BLANK) ? BLANK_LIM : DIGIT_LIM;

    // Counter restarts from zero on every phase change, i.e. at terminal count.
    led_scan_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .limit_i (limit),
        .clear_i (tc),
        .en_i    (1'b1),
        .tc_o    (tc)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        pending_d    = pending_q;
        boundary     = 1'b0;

        if (wr_en) begin
            shadow_d[wr_addr] = wr_data;
        end

        case (state_q)
            BLANK: begin
                if (tc) begin
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (tc) begin
                    state_d  = BLANK;
                    idx_d    = idx_q + 2'd1;
                    boundary = (idx_q == 2'(NUM_DIGITS - 1));
                end
            end
            default: state_d = BLANK;
        endcase

        // The copy takes shadow_d so a write landing on the boundary is included.
        if (boundary) begin
            if (pending_q || commit) begin
                active_d = shadow_d;
            end
            pending_d = 1'b0;
        end else if (commit) begin
            pending_d = 1'b1;
        end

        frame_done_d = boundary;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= BLANK;
            idx_q        <= '0;
            shadow_q     <= '0;
            active_q     <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an             = (state_q == DRIVE) ? anode_sel(idx_q) : AN_OFF;
    assign char           = active_q[idx_q];
    assign commit_pending = pending_q;
    assign frame_done     = frame_done_q;

endmodule
